// File: rtl/oam_dma_engine_if.sv
// Bus bundle between the OAM DMA engine and its CPU register, work RAM and OAM neighbours.
// The engine connects through the master modport; the surrounding system uses slave.
interface oam_dma_engine_if #(
    parameter int RAM_AW = 11
);
    logic              i_reg_we;
    logic [7:0]        i_reg_data;
    logic              o_cpu_halt;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_ram_ce;
    logic              o_ram_rnw;
    logic [RAM_AW-1:0] o_ram_addr;
    logic [7:0]        i_ram_data;
    logic              o_oam_we;
    logic [7:0]        o_oam_addr;
    logic [7:0]        o_oam_data;
    logic [7:0]        i_oam_base;

    modport master (
        input  i_reg_we, i_reg_data, i_ram_data, i_oam_base,
        output o_cpu_halt, o_busy, o_done, o_err,
        output o_ram_ce, o_ram_rnw, o_ram_addr,
        output o_oam_we, o_oam_addr, o_oam_data
    );

    modport slave (
        output i_reg_we, i_reg_data, i_ram_data, i_oam_base,
        input  o_cpu_halt, o_busy, o_done, o_err,
        input  o_ram_ce, o_ram_rnw, o_ram_addr,
        input  o_oam_we, o_oam_addr, o_oam_data
    );
endinterface

// File: rtl/oam_dma_engine.sv
// NES-style sprite DMA: copies XFER_LEN bytes of a work RAM page into OAM while the CPU is halted.
// Optional macro OAM_DMA_BASE_OFFSET_EN offsets OAM writes by OAMADDR captured at the strobe.
module oam_dma_engine #(
    parameter int RAM_AW   = 11,
    parameter int XFER_LEN = 256
) (
    input  logic                 i_clk_cpu,
    input  logic                 i_reset_n,
    oam_dma_engine_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_e;

    localparam int          PAGE_W   = RAM_AW - 8;
    localparam logic [7:0]  LAST_IDX = 8'(XFER_LEN - 1);

    state_e              state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                parity_q, parity_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

`ifdef OAM_DMA_BASE_OFFSET_EN
    logic [7:0]          base_q, base_d;
`else
    logic                unused_base;
    assign unused_base = ^bus.i_oam_base;
`endif

    // Pages $00-$1F are the 2KB work RAM and its mirrors; anything higher is rejected.
    logic strobe_ok;
    assign strobe_ok = bus.i_reg_we && (bus.i_reg_data[7:5] == 3'b000);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        parity_d = ~parity_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef OAM_DMA_BASE_OFFSET_EN
        base_d   = base_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (strobe_ok) begin
                    page_d  = bus.i_reg_data[PAGE_W-1:0];
                    idx_d   = 8'd0;
                    state_d = S_HALT;
`ifdef OAM_DMA_BASE_OFFSET_EN
                    base_d  = bus.i_oam_base;
`endif
                end else if (bus.i_reg_we) begin
                    err_d = 1'b1;
                end
            end
            // Reads must land on parity 0; the alignment cycle fills the gap otherwise.
            S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_cpu) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            page_q   <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef OAM_DMA_BASE_OFFSET_EN
            base_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef OAM_DMA_BASE_OFFSET_EN
            base_q   <= base_d;
`endif
        end
    end

    logic [7:0] oam_index;
`ifdef OAM_DMA_BASE_OFFSET_EN
    assign oam_index = base_q + idx_q;
`else
    assign oam_index = idx_q;
`endif

    // Bus strobes decode straight from the state register, so they drop in the reset cycle.
    always_comb begin
        bus.o_ram_ce   = 1'b0;
        bus.o_ram_addr = '0;
        bus.o_oam_we   = 1'b0;
        bus.o_oam_addr = 8'd0;
        bus.o_oam_data = 8'd0;
        unique case (state_q)
            S_READ: begin
                bus.o_ram_ce   = 1'b1;
                bus.o_ram_addr = {page_q, idx_q};
            end
            S_WRITE: begin
                bus.o_oam_we   = 1'b1;
                bus.o_oam_addr = oam_index;
                bus.o_oam_data = bus.i_ram_data;
            end
            default: ;
        endcase
    end

    assign bus.o_cpu_halt = (state_q != S_IDLE);
    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_ram_rnw  = 1'b1;

    a_ce_we_exclusive: assert property (@(posedge i_clk_cpu) disable iff (!i_reset_n)
        !(bus.o_ram_ce && bus.o_oam_we));
    a_read_on_even: assert property (@(posedge i_clk_cpu) disable iff (!i_reset_n)
        bus.o_ram_ce |-> !parity_q);
endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: expected RAM reads and OAM writes are queued at the strobe.
module tb_oam_dma_engine;
    logic clk;
    logic rst_n;
    logic [7:0] ram_rd;
    int unsigned par_cnt;

    oam_dma_engine_if #(.RAM_AW(11)) bus ();

    oam_dma_engine #(.RAM_AW(11), .XFER_LEN(256)) dut (
        .i_clk_cpu (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity: 0 in the first cycle after the last reset edge, toggling every cycle.
    always @(posedge clk) begin
        if (!rst_n) par_cnt <= 0;
        else        par_cnt <= par_cnt + 1;
    end

    function automatic logic [7:0] ram_byte(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110};
    endfunction

    // Synchronous work RAM: data valid in the cycle after the chip-enable cycle.
    always @(posedge clk) begin
        if (bus.o_ram_ce) ram_rd <= ram_byte(bus.o_ram_addr);
    end
    assign bus.i_ram_data = ram_rd;

    typedef struct packed {
        logic [10:0] src;
        logic [7:0]  oaddr;
    } exp_t;

    exp_t exp_rd_q[$];
    exp_t exp_wr_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"},     32'(bus.o_cpu_halt), 0);
        check({tag, "_busy"},     32'(bus.o_busy), 0);
        check({tag, "_done"},     32'(bus.o_done), 0);
        check({tag, "_err"},      32'(bus.o_err), 0);
        check({tag, "_ram_ce"},   32'(bus.o_ram_ce), 0);
        check({tag, "_ram_rnw"},  32'(bus.o_ram_rnw), 1);
        check({tag, "_ram_addr"}, 32'(bus.o_ram_addr), 0);
        check({tag, "_oam_we"},   32'(bus.o_oam_we), 0);
        check({tag, "_oam_addr"}, 32'(bus.o_oam_addr), 0);
        check({tag, "_oam_data"}, 32'(bus.o_oam_data), 0);
    endtask

    // inject: 0 none, 1 second strobe (page $05) at write #100, 2 one-cycle reset at write #50.
    task automatic run_xfer(input logic [7:0] page, input bit par, input logic [7:0] base,
                            input int inject);
        bit   ok;
        bit   injected;
        bit   in_reset;
        int   halt_cnt, done_cnt, err_cnt, done_k, err_k, first_rd_k, rd_cnt, wr_cnt;
        exp_t e;
        ok = (page[7:5] == 3'b000);
        injected = 0; in_reset = 0;
        halt_cnt = 0; done_cnt = 0; err_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        done_k = -1; err_k = -1; first_rd_k = -1;
        exp_rd_q.delete();
        exp_wr_q.delete();
        if (ok) begin
            for (int i = 0; i < 256; i++) begin
                e.src = {page[2:0], 8'(i)};
`ifdef OAM_DMA_BASE_OFFSET_EN
                e.oaddr = base + 8'(i);
`else
                e.oaddr = 8'(i);
`endif
                exp_rd_q.push_back(e);
                exp_wr_q.push_back(e);
            end
        end

        @(negedge clk);
        if (par_cnt[0] != par) @(negedge clk);
        bus.i_reg_we   = 1'b1;
        bus.i_reg_data = page;
        bus.i_oam_base = base;

        for (int k = 1; k <= 530; k++) begin
            @(negedge clk);
            bus.i_reg_we = 1'b0;
            if (in_reset) begin
                check_reset_outputs("mid_reset");
                rst_n    = 1'b1;
                in_reset = 0;
            end
            check("busy_eq_halt", 32'(bus.o_busy), 32'(bus.o_cpu_halt));
            if (bus.o_cpu_halt) halt_cnt++;
            if (bus.o_done) begin done_cnt++; done_k = k; end
            if (bus.o_err)  begin err_cnt++;  err_k = k;  end
            if (bus.o_ram_ce) begin
                rd_cnt++;
                if (first_rd_k < 0) first_rd_k = k;
                check("ce_we_excl", 32'(bus.o_oam_we), 0);
                check("ram_rnw", 32'(bus.o_ram_rnw), 1);
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e = exp_rd_q.pop_front();
                    check("rd_addr", 32'(bus.o_ram_addr), 32'(e.src));
                end
            end
            if (bus.o_oam_we) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    e = exp_wr_q.pop_front();
                    check("oam_addr", 32'(bus.o_oam_addr), 32'(e.oaddr));
                    check("oam_data", 32'(bus.o_oam_data), 32'(ram_byte(e.src)));
                end
                if (!injected && inject == 1 && wr_cnt == 100) begin
                    bus.i_reg_we   = 1'b1;
                    bus.i_reg_data = 8'h05;
                    injected = 1;
                end
                if (!injected && inject == 2 && wr_cnt == 50) begin
                    rst_n    = 1'b0;
                    in_reset = 1;
                    injected = 1;
                end
            end
        end

        if (inject == 2) begin
            check("rst_wr_cnt", 32'(wr_cnt), 50);
            check("rst_rd_cnt", 32'(rd_cnt), 50);
            check("rst_done_cnt", 32'(done_cnt), 0);
            check("rst_err_cnt", 32'(err_cnt), 0);
        end else if (ok) begin
            check("halt_cycles", 32'(halt_cnt), 32'(513 + int'(par)));
            check("done_cnt", 32'(done_cnt), 1);
            check("done_cycle", 32'(done_k), 32'(514 + int'(par)));
            check("first_read_cycle", 32'(first_rd_k), 32'(2 + int'(par)));
            check("rd_cnt", 32'(rd_cnt), 256);
            check("wr_cnt", 32'(wr_cnt), 256);
            check("err_cnt", 32'(err_cnt), 0);
            check("rd_left", 32'(exp_rd_q.size()), 0);
            check("wr_left", 32'(exp_wr_q.size()), 0);
        end else begin
            check("bad_err_cnt", 32'(err_cnt), 1);
            check("bad_err_cycle", 32'(err_k), 1);
            check("bad_halt", 32'(halt_cnt), 0);
            check("bad_rd_cnt", 32'(rd_cnt), 0);
            check("bad_wr_cnt", 32'(wr_cnt), 0);
            check("bad_done_cnt", 32'(done_cnt), 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_reg_we   = 1'b0;
        bus.i_reg_data = 8'h00;
        bus.i_oam_base = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_xfer(8'h02, 1'b0, 8'hF0, 0);
        run_xfer(8'h02, 1'b1, 8'hF0, 0);
        run_xfer(8'h0B, 1'b0, 8'h00, 0);
        run_xfer(8'h20, 1'b1, 8'h00, 0);
        run_xfer(8'h01, 1'b0, 8'h00, 1);
        run_xfer(8'h03, 1'b1, 8'h00, 2);
        run_xfer(8'h04, 1'b0, 8'h00, 0);
        run_xfer(8'h00, 1'b0, 8'hF0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Sprite-attribute DMA engine sitting directly upstream of the 2KB CPU work RAM; masters the RAM read port while the CPU is halted.
- CPU write of a page number to the DMA register starts a copy of XFER_LEN bytes from work RAM page (page[2:0]<<8, mirrored over $0000-$1FFF) into OAM.
- Fixed NES-style cadence: 1 halt cycle, an optional alignment cycle, then alternating read/write cycles; 513 or 514 CPU cycles in total.

Parameters:
- RAM_AW, 11, work RAM address width (2KB); source address = {page[RAM_AW-9:0], idx[7:0]}.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- i_clk_cpu  in  1  CPU clock; all logic on its rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_reg_we  in  1  one-cycle strobe: CPU write to DMA page register.
- i_reg_data  in  8  page number written with i_reg_we.
- o_cpu_halt  out  1  stalls CPU while the engine owns the RAM.
- o_busy  out  1  engine not IDLE.
- o_done  out  1  one-cycle pulse after the last OAM write.
- o_err  out  1  one-cycle pulse: rejected (non-RAM) page.
- o_ram_ce  out  1  work RAM chip enable.
- o_ram_rnw  out  1  work RAM read/not-write; always 1.
- o_ram_addr  out  RAM_AW  work RAM address.
- i_ram_data  in  8  work RAM read data; valid 1 cycle after the o_ram_ce cycle.
- o_oam_we  out  1  OAM write strobe.
- o_oam_addr  out  8  OAM byte index.
- o_oam_data  out  8  OAM write data.
- i_oam_base  in  8  current OAMADDR; used only with the optional feature.

Behaviour:
- Reset (i_reset_n=0 at an edge):
  - State IDLE; idx=0; parity flop=0.
  - o_cpu_halt, o_busy, o_done, o_err, o_ram_ce, o_oam_we all 0.
  - o_ram_addr, o_oam_addr, o_oam_data all 0; o_ram_rnw=1.
- Parity flop:
  - Toggles every cycle, starting at 0 in the first cycle after reset release.
  - READ cycles only occur with parity=0.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - i_reg_we with i_reg_data[7:5]==0: latch page, idx<=0, go HALT.
  - i_reg_we with i_reg_data[7:5]!=0: stay IDLE, pulse o_err next cycle, no halt.
- HALT (1 cycle): next state READ if parity==1 in this cycle (so READ lands on parity 0), else ALIGN.
- ALIGN (1 cycle): go READ.
- READ: o_ram_ce=1, o_ram_addr={page[2:0],idx}, both combinational from state; go WRITE.
- WRITE:
  - o_oam_we=1, o_oam_data=i_ram_data, o_oam_addr=idx.
  - If idx==XFER_LEN-1: go IDLE. Otherwise idx<=idx+1 and go READ.
- o_cpu_halt and o_busy:
  - High in every HALT/ALIGN/READ/WRITE cycle, i.e. from the cycle after the strobe through the last WRITE, inclusive.
  - Low in the o_done cycle.
- o_done: high exactly in the first IDLE cycle after the final WRITE.
- Strobe while busy: ignored; no restart, no o_err, page unchanged.
- Reset mid-transfer: immediate return to IDLE with reset values; no further RAM reads or OAM writes; no o_done.
- o_ram_ce and o_oam_we are never high in the same cycle.
- idx is 8 bits wide; o_oam_addr wraps modulo 256.

Optional Feature:
- Macro OAM_DMA_BASE_OFFSET_EN.
- Defined:
  - i_oam_base is sampled with the accepted strobe.
  - o_oam_addr = (base + idx) mod 256, so writes wrap from $FF to $00.
  - RAM source addressing is unchanged.
- Undefined: i_oam_base is ignored; o_oam_addr = idx.

Test Plan:
- Reset release, strobe page $02 at parity 0 (HALT cycle has parity 1):
  - o_cpu_halt high for 513 cycles.
  - o_ram_addr $200..$2FF, OAM writes 0..255 carrying RAM contents.
  - o_done pulses once, in cycle 514 after the strobe.
- Same test, strobe at parity 1: ALIGN inserted; halt lasts 514 cycles; first READ has parity 0.
- Strobe page $0B (mirror):
  - Reads addresses $300..$3FF.
  - Strobe page $20: o_err pulses, o_busy stays 0, no RAM/OAM activity.
- Second strobe (page $05) at write #100 of a page $01 transfer: ignored; all 256 sources remain in page $01.
- i_reset_n low for one cycle at write #50:
  - Next cycle: all outputs at reset values, exactly 50 OAM writes seen, no o_done.
  - A fresh strobe afterwards completes normally.
- OAM_DMA_BASE_OFFSET_EN defined, i_oam_base=$F0, page $00:
  - First OAM write to $F0, RAM byte $010 lands at OAM $00, last write to $EF.
